// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM encoding and
// the size of the length header that precedes every image.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/instruction_loader.sv
// Length-prefixed byte-stream loader driving the byte write port of the
// big-endian instruction memory; holds the core while an image is loading.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int          BUS_WIDTH = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 mem_wr_en,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [7:0]           mem_wr_data,
    output logic                 busy,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [BUS_WIDTH-1:0] words_loaded
);

    localparam int FW = BUS_WIDTH + 2;
    localparam int LW = HDR_BYTES * 8;

    state_e               state_q, state_d;
    logic [LW-1:0]        len_q, len_d;
    logic [FW-1:0]        idx_q, idx_d;
    logic                 err_q, err_d;
    logic [BUS_WIDTH-1:0] words_q, words_d;
    logic                 wr_en_q, wr_en_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 xfer;
    logic                 last_byte;
    logic [LW-1:0]        len_full;

    // Widened so that BASE_ADDR + 2*LEN cannot overflow before the compare.
    function automatic logic image_fits(input logic [LW-1:0] len);
        logic [FW-1:0] need;
        need = FW'(BASE_ADDR) + (FW'(len) << 1);
        return need <= (FW'(1) << BUS_WIDTH);
    endfunction

    assign in_ready  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA);
    assign xfer      = in_valid && in_ready;
    assign last_byte = (idx_q == ((FW'(len_q) << 1) - FW'(1)));
    assign len_full  = {len_q[LW-1 -: 8], in_data};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        err_d   = err_q;
        words_d = words_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    err_d   = 1'b0;
                    words_d = '0;
                    idx_d   = '0;
                    len_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d[LW-1 -: 8] = in_data;
                    state_d          = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d = ST_DONE;
                    end else if (!image_fits(len_full)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    wr_en_d = 1'b1;
                    addr_d  = BUS_WIDTH'(BASE_ADDR) + idx_q[BUS_WIDTH-1:0];
                    wdata_d = in_data;
                    idx_d   = idx_q + FW'(1);
                    // Odd offset carries the low byte, completing a word.
                    if (idx_q[0]) begin
                        words_d = words_q + BUS_WIDTH'(1);
                    end
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            words_q <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            words_q <= words_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_wr_en    = wr_en_q;
    assign mem_addr     = addr_q;
    assign mem_wr_data  = wdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign cpu_hold     = busy;
    assign done         = (state_q == ST_DONE);
    assign error        = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: two instances (base 0 and base 0xFFFC) share one
// stimulus stream and are checked every cycle against a stream-level model.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic [1:0]  rdy, wen, bsy, hld, dn, er;
    logic [15:0] addr [2];
    logic [7:0]  wdat [2];
    logic [15:0] wrds [2];

    always #5 clk = ~clk;

    instruction_loader #(.BUS_WIDTH(16), .BASE_ADDR(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .mem_wr_en(wen[0]), .mem_addr(addr[0]), .mem_wr_data(wdat[0]),
        .busy(bsy[0]), .cpu_hold(hld[0]), .done(dn[0]), .error(er[0]), .words_loaded(wrds[0]));

    instruction_loader #(.BUS_WIDTH(16), .BASE_ADDR(32'hFFFC)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .mem_wr_en(wen[1]), .mem_addr(addr[1]), .mem_wr_data(wdat[1]),
        .busy(bsy[1]), .cpu_hold(hld[1]), .done(dn[1]), .error(er[1]), .words_loaded(wrds[1]));

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Stream-level model: counts header bytes and payload bytes received.
    int  base [2] = '{0, 32'hFFFC};
    bit  m_load [2], m_fin [2], m_err [2], e_wr [2];
    int  m_hdr [2], m_len [2], m_total [2], m_got [2], m_words [2];
    int  e_addr [2], e_data [2];

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    m_load[d] = 0; m_fin[d] = 0; m_err[d] = 0; e_wr[d] = 0;
                    m_hdr[d] = 0; m_len[d] = 0; m_total[d] = 0; m_got[d] = 0; m_words[d] = 0;
                end else begin
                    e_wr[d] = 0;
                    if (m_fin[d]) begin
                        m_fin[d] = 0; m_load[d] = 0;
                    end else if (!m_load[d]) begin
                        if (start) begin
                            m_load[d] = 1; m_hdr[d] = 0; m_len[d] = 0; m_got[d] = 0;
                            m_err[d] = 0; m_words[d] = 0;
                        end
                    end else if (in_valid) begin
                        if (m_hdr[d] < 2) begin
                            m_len[d] = m_len[d] * 256 + int'(in_data);
                            m_hdr[d]++;
                            if (m_hdr[d] == 2) begin
                                m_total[d] = 2 * m_len[d];
                                if (base[d] + m_total[d] > 65536) begin
                                    m_err[d] = 1; m_fin[d] = 1;
                                end else if (m_total[d] == 0) begin
                                    m_fin[d] = 1;
                                end
                            end
                        end else begin
                            e_wr[d] = 1; e_addr[d] = base[d] + m_got[d]; e_data[d] = int'(in_data);
                            m_got[d]++;
                            if (m_got[d] % 2 == 0) m_words[d]++;
                            if (m_got[d] == m_total[d]) m_fin[d] = 1;
                        end
                    end
                end
            end
        end
    end

    // Bench-side copy of memory contents plus per-load write/done counters.
    logic [7:0] mem0 [int];
    logic [7:0] mem1 [int];
    int wc [2], dc [2];

    function automatic logic [7:0] rd(input int d, input int a);
        if (d == 0) return mem0.exists(a) ? mem0[a] : 8'hxx;
        return mem1.exists(a) ? mem1[a] : 8'hxx;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (wen[d] === 1'b1) begin
                    wc[d]++;
                    if (d == 0) mem0[int'(addr[0])] = wdat[0];
                    else        mem1[int'(addr[1])] = wdat[1];
                end
                if (dn[d] === 1'b1) dc[d]++;
                if (chk_en) begin
                    chk("in_ready", d, 32'(rdy[d]), 32'(m_load[d] && !m_fin[d]));
                    chk("busy", d, 32'(bsy[d]), 32'(m_load[d]));
                    chk("cpu_hold", d, 32'(hld[d]), 32'(m_load[d]));
                    chk("done", d, 32'(dn[d]), 32'(m_fin[d]));
                    chk("error", d, 32'(er[d]), 32'(m_err[d]));
                    chk("words_loaded", d, 32'(wrds[d]), 32'(m_words[d]));
                    chk("mem_wr_en", d, 32'(wen[d]), 32'(e_wr[d]));
                    if (e_wr[d]) begin
                        chk("mem_addr", d, 32'(addr[d]), 32'(e_addr[d]));
                        chk("mem_wr_data", d, 32'(wdat[d]), 32'(e_data[d]));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        wc[0] = 0; wc[1] = 0; dc[0] = 0; dc[1] = 0;
        mem0.delete(); mem1.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents each byte until instance 0 accepts it; gap idle cycles precede each byte.
    task automatic send(input logic [7:0] bytes [$], input int gap, input bit hold_start);
        int n;
        for (int i = 0; i < bytes.size(); i++) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                start    = 1'b0;
                repeat (gap) tick();
            end
            in_valid = 1'b1;
            in_data  = bytes[i];
            start    = hold_start && (i >= 2);
            n = 0;
            while (rdy[0] !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) chk("source_timeout", 0, 32'(n), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bsy[0] !== 1'b0 || bsy[1] !== 1'b0) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("idle_timeout", 0, 32'(n), 32'd0);
        tick();
    endtask

    logic [7:0] nominal [$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    logic [7:0] zero    [$] = '{8'h00, 8'h00};
    logic [7:0] three   [$] = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] partial [$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};

    task automatic check_nominal(input string tag);
        chk({tag, "_wc"}, 0, 32'(wc[0]), 32'd4);
        chk({tag, "_wc"}, 1, 32'(wc[1]), 32'd4);
        chk({tag, "_dc"}, 0, 32'(dc[0]), 32'd1);
        chk({tag, "_w0"}, 0, 32'({rd(0, 0), rd(0, 1)}), 32'h1234);
        chk({tag, "_w2"}, 0, 32'({rd(0, 2), rd(0, 3)}), 32'hABCD);
        chk({tag, "_wFFFC"}, 1, 32'({rd(1, 'hFFFC), rd(1, 'hFFFD)}), 32'h1234);
        chk({tag, "_wFFFE"}, 1, 32'({rd(1, 'hFFFE), rd(1, 'hFFFF)}), 32'hABCD);
        chk({tag, "_words"}, 0, 32'(wrds[0]), 32'd2);
        chk({tag, "_error"}, 1, 32'(er[1]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        chk_en = 1;
        chk("rst_wr_en", 0, 32'(wen[0]), 32'd0);
        chk("rst_addr", 0, 32'(addr[0]), 32'd0);
        chk("rst_data", 0, 32'(wdat[0]), 32'd0);
        chk("rst_busy", 1, 32'(bsy[1]), 32'd0);
        rst = 1'b0;
        tick();

        // Bytes offered while idle must not be accepted.
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) tick();
        chk("idle_ready", 0, 32'(rdy[0]), 32'd0);
        in_valid = 1'b0;

        pulse_start();
        send(nominal, 0, 0);
        wait_idle();
        check_nominal("nominal");

        pulse_start();
        send(nominal, 2, 0);
        wait_idle();
        check_nominal("backpressure");

        pulse_start();
        send(nominal, 0, 1);
        wait_idle();
        check_nominal("start_in_data");

        pulse_start();
        send(zero, 0, 0);
        wait_idle();
        chk("zero_wc", 0, 32'(wc[0]), 32'd0);
        chk("zero_dc", 0, 32'(dc[0]), 32'd1);
        chk("zero_words", 0, 32'(wrds[0]), 32'd0);
        chk("zero_error", 0, 32'(er[0]), 32'd0);

        pulse_start();
        send(three, 0, 0);
        wait_idle();
        chk("ovf_error", 1, 32'(er[1]), 32'd1);
        chk("ovf_wc", 1, 32'(wc[1]), 32'd0);
        chk("ovf_dc", 1, 32'(dc[1]), 32'd1);
        chk("len3_words", 0, 32'(wrds[0]), 32'd3);
        chk("len3_wc", 0, 32'(wc[0]), 32'd6);
        repeat (3) tick();
        chk("ovf_sticky", 1, 32'(er[1]), 32'd1);

        pulse_start();
        send(partial, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_wr_en", 0, 32'(wen[0]), 32'd0);
        chk("abort_busy", 0, 32'(bsy[0]), 32'd0);
        chk("abort_words", 0, 32'(wrds[0]), 32'd0);
        chk("abort_ready", 0, 32'(rdy[0]), 32'd0);
        chk("abort_wc", 0, 32'(wc[0]), 32'd3);
        tick();

        pulse_start();
        send(nominal, 0, 0);
        wait_idle();
        check_nominal("after_abort");

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
